// File: rtl/cache_event_counter_bank_pkg.sv
// Shared definitions for the cache performance-counter bank: comm_i bit positions,
// readout address map, read-select decoding and the words-per-channel helper.
package cache_event_counter_bank_pkg;

  localparam int RUN_BIT  = 24;
  localparam int SNAP_BIT = 25;
  localparam int CLR_BIT  = 26;

  localparam logic [11:0] ADDR_OVF_LO = 12'hF00;
  localparam logic [11:0] ADDR_OVF_HI = 12'hF01;
  localparam logic [11:0] ADDR_STATUS = 12'hFFE;
  localparam logic [11:0] ADDR_ID     = 12'hFFF;
  localparam int          ADDR_LIMIT  = 'hF00;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_SHADOW,
    SEL_OVF_LO,
    SEL_OVF_HI,
    SEL_STATUS,
    SEL_ID
  } readSel_e;

  function automatic int wordsPerChannel(input int cntWidth);
    return (cntWidth + 31) / 32;
  endfunction

  // Shadow words occupy the bottom of the map; fixed registers live at the top.
  function automatic readSel_e decodeAddr(input logic [11:0] addr, input int nShadowWords);
    readSel_e sel;
    if (int'(addr) < nShadowWords) begin
      sel = SEL_SHADOW;
    end else begin
      case (addr)
        ADDR_OVF_LO: sel = SEL_OVF_LO;
        ADDR_OVF_HI: sel = SEL_OVF_HI;
        ADDR_STATUS: sel = SEL_STATUS;
        ADDR_ID:     sel = SEL_ID;
        default:     sel = SEL_NONE;
      endcase
    end
    return sel;
  endfunction

endpackage

// File: rtl/cache_event_counter.sv
// One event channel: edge history, live counter with sticky overflow, and the
// shadow register that captures the live value on a snapshot request.
module cache_event_counter
  import cache_event_counter_bank_pkg::*;
#(
  parameter int CNT_WIDTH = 64,
  parameter bit EDGE      = 1'b0,
  parameter bit SATURATE  = 1'b0
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_event,
  input  logic                 i_run,
  input  logic                 i_snap,
  input  logic                 i_clear,
  output logic [CNT_WIDTH-1:0] o_shadow,
  output logic                 o_ovf
);

  localparam logic [CNT_WIDTH-1:0] ONE = CNT_WIDTH'(1);

  logic                 r_prevEvent;
  logic [CNT_WIDTH-1:0] r_count;
  logic [CNT_WIDTH-1:0] r_shadow;
  logic                 r_ovf;
  logic                 w_inc;
  logic                 w_atMax;

  assign w_inc   = i_run & (EDGE ? (r_prevEvent & ~i_event) : i_event);
  assign w_atMax = &r_count;

  // Shadow samples the pre-increment, pre-clear value; clear wins over any event.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_prevEvent <= 1'b0;
      r_count     <= '0;
      r_shadow    <= '0;
      r_ovf       <= 1'b0;
    end else begin
      r_prevEvent <= i_event;
      if (i_snap) begin
        r_shadow <= r_count;
      end
      if (i_clear) begin
        r_count <= '0;
        r_ovf   <= 1'b0;
      end else if (w_inc) begin
        if (w_atMax) begin
          r_ovf   <= 1'b1;
          r_count <= SATURATE ? r_count : '0;
        end else begin
          r_count <= r_count + ONE;
        end
      end
    end
  end

  assign o_shadow = r_shadow;
  assign o_ovf    = r_ovf;

endmodule

// File: rtl/cache_event_counter_bank.sv
// Generic cache performance-counter bank: per-channel counters with coherent
// snapshot shadows, read out word by word over the 32-bit comm path.
module cache_event_counter_bank
  import cache_event_counter_bank_pkg::*;
#(
  parameter int                  N_EVENTS  = 10,
  parameter int                  CNT_WIDTH = 64,
  parameter logic [N_EVENTS-1:0] EDGE_MASK = '0,
  parameter bit                  SATURATE  = 1'b0,
  parameter logic [31:0]         CACHE_ID  = 32'h0
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic [N_EVENTS-1:0] event_i,
  input  logic [31:0]         comm_i,
  output logic [31:0]         comm_o,
  output logic                snapshot_done_o,
  output logic                overflow_o
);

  localparam int W       = wordsPerChannel(CNT_WIDTH);
  localparam int N_WORDS = N_EVENTS * W;

  if (N_EVENTS < 1 || N_EVENTS > 64 || CNT_WIDTH < 1 || CNT_WIDTH > 128 ||
      N_WORDS >= ADDR_LIMIT) begin : g_paramCheck
    $error("cache_event_counter_bank: illegal N_EVENTS/CNT_WIDTH combination");
  end

  logic                r_prevSnap;
  logic                r_prevClear;
  logic [15:0]         r_snapCount;
  logic                r_snapDone;
  logic [31:0]         r_commO;
  logic                w_run;
  logic                w_snapReq;
  logic                w_clearReq;
  logic [N_EVENTS-1:0] w_ovf;
  logic [63:0]         w_ovfPad;
  logic [31:0]         w_shadowWords [N_WORDS];
  logic [31:0]         w_readData;
  readSel_e            w_sel;
  logic                w_unusedComm;

  assign w_run        = comm_i[RUN_BIT];
  assign w_snapReq    = comm_i[SNAP_BIT] & ~r_prevSnap;
  assign w_clearReq   = comm_i[CLR_BIT] & ~r_prevClear;
  assign w_unusedComm = ^{comm_i[31:27], comm_i[23:12]};

  for (genvar k = 0; k < N_EVENTS; k++) begin : g_chan
    logic [CNT_WIDTH-1:0] w_shadow;
    logic [W*32-1:0]      w_shadowPad;

    cache_event_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .EDGE      (EDGE_MASK[k]),
      .SATURATE  (SATURATE)
    ) u_counter (
      .i_clock  (clock_i),
      .i_reset  (reset_i),
      .i_event  (event_i[k]),
      .i_run    (w_run),
      .i_snap   (w_snapReq),
      .i_clear  (w_clearReq),
      .o_shadow (w_shadow),
      .o_ovf    (w_ovf[k])
    );

    always_comb begin
      w_shadowPad                = '0;
      w_shadowPad[CNT_WIDTH-1:0] = w_shadow;
    end

    for (genvar j = 0; j < W; j++) begin : g_word
      assign w_shadowWords[k*W+j] = w_shadowPad[j*32 +: 32];
    end
  end

  always_comb begin
    w_ovfPad                 = '0;
    w_ovfPad[N_EVENTS-1:0]   = w_ovf;
  end

  // Read data is decoded from the current shadows so a same-cycle snapshot returns old data.
  always_comb begin
    w_readData = '0;
    w_sel      = decodeAddr(comm_i[11:0], N_WORDS);
    case (w_sel)
      SEL_SHADOW: begin
        for (int i = 0; i < N_WORDS; i++) begin
          if (comm_i[11:0] == 12'(i)) begin
            w_readData = w_shadowWords[i];
          end
        end
      end
      SEL_OVF_LO: w_readData = w_ovfPad[31:0];
      SEL_OVF_HI: w_readData = w_ovfPad[63:32];
      SEL_STATUS: w_readData = {r_snapCount, 15'b0, w_run};
      SEL_ID:     w_readData = CACHE_ID;
      default:    w_readData = '0;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_prevSnap  <= 1'b0;
      r_prevClear <= 1'b0;
      r_snapCount <= '0;
      r_snapDone  <= 1'b0;
      r_commO     <= '0;
    end else begin
      r_prevSnap  <= comm_i[SNAP_BIT];
      r_prevClear <= comm_i[CLR_BIT];
      if (w_snapReq) begin
        r_snapCount <= r_snapCount + 16'd1;
      end
      r_snapDone  <= w_snapReq;
      r_commO     <= w_readData;
    end
  end

  assign comm_o          = r_commO;
  assign snapshot_done_o = r_snapDone;
  assign overflow_o      = |w_ovf;

endmodule

// File: tb/tb_cache_event_counter_bank.sv
// Scoreboard bench: three bank configurations share one stimulus stream and are
// checked against an array-based reference model of the counting rules.
module tb_cache_event_counter_bank;

  localparam int NI = 3;

  logic        clock;
  logic        reset;
  logic [3:0]  ev;
  logic [31:0] comm;
  logic [31:0] commA, commB, commC;
  logic        doneA, doneB, doneC;
  logic        ovfA, ovfB, ovfC;

  cache_event_counter_bank #(
    .N_EVENTS(4), .CNT_WIDTH(4), .EDGE_MASK(4'b0010), .SATURATE(1'b0), .CACHE_ID(32'hCAFE_0A0A)
  ) dutA (
    .clock_i(clock), .reset_i(reset), .event_i(ev), .comm_i(comm),
    .comm_o(commA), .snapshot_done_o(doneA), .overflow_o(ovfA)
  );

  cache_event_counter_bank #(
    .N_EVENTS(4), .CNT_WIDTH(4), .EDGE_MASK(4'b0100), .SATURATE(1'b1), .CACHE_ID(32'h0000_B00B)
  ) dutB (
    .clock_i(clock), .reset_i(reset), .event_i(ev), .comm_i(comm),
    .comm_o(commB), .snapshot_done_o(doneB), .overflow_o(ovfB)
  );

  cache_event_counter_bank #(
    .N_EVENTS(4), .CNT_WIDTH(36), .EDGE_MASK(4'b0001), .SATURATE(1'b0), .CACHE_ID(32'h1234_5678)
  ) dutC (
    .clock_i(clock), .reset_i(reset), .event_i(ev), .comm_i(comm),
    .comm_o(commC), .snapshot_done_o(doneC), .overflow_o(ovfC)
  );

  int          pWidth [NI] = '{4, 4, 36};
  bit          pSat   [NI] = '{1'b0, 1'b1, 1'b0};
  logic [3:0]  pEdge  [NI] = '{4'b0010, 4'b0100, 4'b0001};
  logic [31:0] pId    [NI] = '{32'hCAFE_0A0A, 32'h0000_B00B, 32'h1234_5678};
  int          pWords [NI] = '{1, 1, 2};

  longint unsigned mLive   [NI][4];
  longint unsigned mShadow [NI][4];
  bit              mOvf    [NI][4];
  logic [15:0]     mSnapCnt;
  logic [3:0]      mPrevEv;
  bit              mPrevSnap;
  bit              mPrevClr;

  typedef struct {
    int          issue;
    logic [11:0] addr;
    logic [95:0] rd;
    logic [2:0]  ovf;
    logic        done;
  } exp_t;

  exp_t expQ[$];
  exp_t monItem;
  int   checks   = 0;
  int   errors   = 0;
  int   cycleCnt = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cycleCnt <= cycleCnt + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] modelRead(input int inst, input logic [11:0] a, input bit run);
    int          ai = int'(a);
    logic [31:0] r  = '0;
    if (ai < 4 * pWords[inst]) begin
      int ch = ai / pWords[inst];
      int wd = ai % pWords[inst];
      r = 32'(mShadow[inst][ch] >> (32 * wd));
    end else if (a == 12'hF00) begin
      for (int ch = 0; ch < 4; ch++) r[ch] = mOvf[inst][ch];
    end else if (a == 12'hFFE) begin
      r = {mSnapCnt, 15'b0, run};
    end else if (a == 12'hFFF) begin
      r = pId[inst];
    end
    return r;
  endfunction

  task automatic applyStimulus(input logic [3:0] e, input bit run, input bit snap, input bit clr,
                               input logic [11:0] addr, input bit rst);
    exp_t            x;
    bit              snapReq, clrReq, inc;
    longint unsigned maxv;
    @(negedge clock);
    reset   = rst;
    ev      = e;
    comm    = {5'b0, clr, snap, run, 12'b0, addr};
    x.issue = cycleCnt;
    x.addr  = addr;
    x.rd    = '0;
    x.ovf   = '0;
    x.done  = 1'b0;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        for (int ch = 0; ch < 4; ch++) begin
          mLive[i][ch]   = 0;
          mShadow[i][ch] = 0;
          mOvf[i][ch]    = 1'b0;
        end
      end
      mSnapCnt  = '0;
      mPrevEv   = '0;
      mPrevSnap = 1'b0;
      mPrevClr  = 1'b0;
    end else begin
      snapReq = snap && !mPrevSnap;
      clrReq  = clr && !mPrevClr;
      for (int i = 0; i < NI; i++) x.rd[i*32 +: 32] = modelRead(i, addr, run);
      for (int i = 0; i < NI; i++) begin
        maxv = (64'd1 << pWidth[i]) - 64'd1;
        for (int ch = 0; ch < 4; ch++) begin
          inc = run && (pEdge[i][ch] ? (mPrevEv[ch] && !e[ch]) : e[ch]);
          if (snapReq) mShadow[i][ch] = mLive[i][ch];
          if (clrReq) begin
            mLive[i][ch] = 0;
            mOvf[i][ch]  = 1'b0;
          end else if (inc) begin
            if (mLive[i][ch] == maxv) begin
              mOvf[i][ch]  = 1'b1;
              mLive[i][ch] = pSat[i] ? maxv : 64'd0;
            end else begin
              mLive[i][ch] = mLive[i][ch] + 1;
            end
          end
          if (mOvf[i][ch]) x.ovf[i] = 1'b1;
        end
      end
      if (snapReq) mSnapCnt = mSnapCnt + 16'd1;
      mPrevEv   = e;
      mPrevSnap = snap;
      mPrevClr  = clr;
      x.done    = snapReq;
    end
    expQ.push_back(x);
  endtask

  always @(negedge clock) begin
    if (expQ.size() > 0 && expQ[0].issue < cycleCnt) begin
      monItem = expQ.pop_front();
      checkOutput($sformatf("commA@%03h", monItem.addr), commA, monItem.rd[31:0]);
      checkOutput($sformatf("commB@%03h", monItem.addr), commB, monItem.rd[63:32]);
      checkOutput($sformatf("commC@%03h", monItem.addr), commC, monItem.rd[95:64]);
      checkOutput("doneA", {31'b0, doneA}, {31'b0, monItem.done});
      checkOutput("doneB", {31'b0, doneB}, {31'b0, monItem.done});
      checkOutput("doneC", {31'b0, doneC}, {31'b0, monItem.done});
      checkOutput("ovfA", {31'b0, ovfA}, {31'b0, monItem.ovf[0]});
      checkOutput("ovfB", {31'b0, ovfB}, {31'b0, monItem.ovf[1]});
      checkOutput("ovfC", {31'b0, ovfC}, {31'b0, monItem.ovf[2]});
    end
  end

  initial begin
    logic [3:0]  e;
    logic [11:0] a;
    reset = 1'b1;
    ev    = '0;
    comm  = '0;
    $display("[TB] starting cache_event_counter_bank bench");

    repeat (3) applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 12'hFFF, 1'b1);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'hFFF, 1'b0);

    // Level counting on channel 0, then snapshot and read both words.
    repeat (10) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 12'hFFE, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h001, 1'b0);

    // Channel 1 pulses: edge channel in dutA, level in the others.
    repeat (5) begin
      repeat (3) applyStimulus(4'b0010, 1'b1, 1'b0, 1'b0, 12'h002, 1'b0);
      applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h002, 1'b0);
    end
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 12'h001, 1'b0);
    for (int i = 1; i < 5; i++) applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'(i), 1'b0);

    // Run toggling with no activity.
    for (int i = 0; i < 6; i++) applyStimulus(4'h0, i[0], 1'b0, 1'b0, 12'hFFE, 1'b0);

    // Overflow on channel 3 then clear.
    repeat (17) applyStimulus(4'b1000, 1'b1, 1'b0, 1'b0, 12'hF00, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 12'h003, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h003, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h007, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b1, 12'hF00, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'hF00, 1'b0);

    // Simultaneous snapshot and clear, then a second snapshot.
    repeat (7) applyStimulus(4'b0001, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'b0001, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'hFFE, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'h800, 1'b0);

    // Reset with a held snapshot request, then re-arm the request.
    repeat (5) applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    repeat (2) applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 12'h000, 1'b1);
    repeat (4) applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 12'hFFE, 1'b0);
    applyStimulus(4'hF, 1'b1, 1'b0, 1'b0, 12'hFFE, 1'b0);
    applyStimulus(4'hF, 1'b1, 1'b1, 1'b0, 12'h000, 1'b0);
    applyStimulus(4'h0, 1'b1, 1'b0, 1'b0, 12'hFFE, 1'b0);

    // Randomised traffic.
    repeat (600) begin
      e = 4'($urandom);
      case ($urandom_range(0, 5))
        0:       a = 12'hF00;
        1:       a = 12'hF01;
        2:       a = 12'hFFE;
        3:       a = 12'hFFF;
        4:       a = 12'($urandom);
        default: a = 12'($urandom_range(0, 8));
      endcase
      applyStimulus(e, $urandom_range(0, 7) != 0, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 29) == 0, a, $urandom_range(0, 199) == 0);
    end

    applyStimulus(4'h0, 1'b0, 1'b0, 1'b0, 12'hFFF, 1'b0);
    @(negedge clock);
    @(negedge clock);
    #1;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending, expected 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
